id_ex_pipe_rg: RTL
==================

Name: id_ex_pipe_rg

Overview:
- Parametrised, elastic successor to the fixed ID/EX stage register.
- Carries decode payload (rs1/rs2 values, rd index, instruction word, instruction type) from ID to EX.
- Uses a valid/ready handshake with a 2-entry skid buffer, so EX back-pressure never creates a combinational ready path back into ID.
- Adds a synchronous flush that squashes in-flight beats and presents a NOP bubble for branch/exception recovery.

Parameters:
- XLEN, 32, width of rs1/rs2 operand values.
- REG_IDX_W, 5, width of destination register index.
- INSTR_W, 32, width of instruction word.
- TYPE_W, 4, width of instruction-type code.
- NOP_INSTR, 32'h0000_0013, instruction word driven for squashed or reset entries (addi x0,x0,0).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous squash of all held beats.
- in_valid  in  1  ID beat valid.
- in_ready  out  1  stage can accept a beat.
- rs1_val  in  XLEN  operand 1.
- rs2_val  in  XLEN  operand 2.
- rd_idx  in  REG_IDX_W  destination index.
- instr  in  INSTR_W  instruction word.
- instr_type  in  TYPE_W  decoded type.
- out_valid  out  1  EX beat valid.
- out_ready  in  1  EX accepts beat.
- rs1_val_out  out  XLEN  registered operand 1.
- rs2_val_out  out  XLEN  registered operand 2.
- rd_idx_out  out  REG_IDX_W  registered destination index.
- instr_out  out  INSTR_W  registered instruction word.
- instr_type_out  out  TYPE_W  registered type.
- occupancy  out  2  beats held (0..2).

Behaviour:
- Reset (rst_n=0, asynchronous):
  - out_valid=0, occupancy=0.
  - Both the main and skid payloads clear: rs1/rs2/rd/type=0, instr=NOP_INSTR.
  - in_ready=1 once rst_n deasserts.
- Handshake:
  - Accept = in_valid & in_ready.
  - Fire = out_valid & out_ready.
  - Output payload ports always reflect the main register. Payload is don't-care to EX when out_valid=0, but must equal the NOP pattern after reset or flush.
- State (occupancy): EMPTY(0), ONE(1), TWO(2).
- Ready rules:
  - in_ready = (occupancy != 2) & ~flush.
  - This is the only combinational input-to-output path, and it exists only through flush.
  - out_valid = (occupancy != 0), registered.
- Transitions (no flush):
  - EMPTY: accept -> ONE, main<=in.
  - ONE, accept & fire -> ONE, main<=in.
  - ONE, fire only -> EMPTY.
  - ONE, accept only -> TWO, skid<=in.
  - ONE, neither -> ONE, hold.
  - TWO: in_ready=0. Fire -> ONE, main<=skid. Otherwise hold.
- Latency and throughput:
  - A beat accepted at edge N is on the outputs with out_valid=1 after edge N, i.e. 1 cycle.
  - Sustained 1 beat/cycle when out_ready=1.
  - Order is strictly FIFO; no beat is ever duplicated or dropped except by flush.
- Flush (synchronous, highest priority):
  - At the edge, occupancy<=0 and out_valid<=0.
  - Main and skid payloads load the NOP pattern.
  - A beat presented during the flush cycle is not accepted (in_ready=0).
  - A fire in the flush cycle still counts as consumed by EX.
  - Flush held across multiple cycles keeps the stage empty.
- Payload registers are updated only on the transitions listed above; they hold otherwise, with no enable glitches.
- Reset mid-operation:
  - Asynchronous assertion clears everything immediately, regardless of occupancy.
  - No partial beat survives.

Test Plan:
- Reset release, out_ready=1, stream instr=0x00A00093,0x00B00113,0x00C00193 on consecutive cycles -> each appears one cycle later; out_valid continuous; occupancy=1 throughout.
- Accept beat A (rs1=0x11), drop out_ready for 2 cycles while presenting B (rs1=0x22) -> occupancy 1->2; in_ready=0 in the second cycle; re-raise out_ready -> A then B emitted in order, no loss.
- Occupancy=2, assert flush one cycle with in_valid=1 (instr=0xDEADBEEF) -> next cycle out_valid=0, occupancy=0, instr_out=0x00000013, rd_idx_out=0; 0xDEADBEEF never appears on the outputs.
- Assert rst_n=0 asynchronously mid-cycle with occupancy=2 -> outputs clear before the next clk edge; instr_out=NOP_INSTR; after release in_ready=1.
- Random in_valid/out_ready (10k cycles, 50% each) against a scoreboard FIFO -> output sequence equals input sequence; occupancy never exceeds 2; in_ready==0 iff occupancy==2 or flush.
- Instantiate XLEN=64, REG_IDX_W=6 -> rs1_val=0xFFFF_0000_1234_5678 and rd_idx=63 pass through intact.

Source files
------------

// File: rtl/id_ex_pipe_rg.sv
// ID/EX stage register with a valid/ready handshake and a 2-entry skid buffer.
// The main register always drives the EX-side payload. The skid register
// catches the one extra beat that can arrive while EX stalls, so in_ready
// never depends combinationally on out_ready. A synchronous flush squashes
// every held beat and parks a NOP bubble on the outputs.

module id_ex_pipe_rg #(
    parameter int XLEN      = 32,
    parameter int REG_IDX_W = 5,
    parameter int INSTR_W   = 32,
    parameter int TYPE_W    = 4,
    parameter logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [XLEN-1:0]      rs1_val,
    input  logic [XLEN-1:0]      rs2_val,
    input  logic [REG_IDX_W-1:0] rd_idx,
    input  logic [INSTR_W-1:0]   instr,
    input  logic [TYPE_W-1:0]    instr_type,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [XLEN-1:0]      rs1_val_out,
    output logic [XLEN-1:0]      rs2_val_out,
    output logic [REG_IDX_W-1:0] rd_idx_out,
    output logic [INSTR_W-1:0]   instr_out,
    output logic [TYPE_W-1:0]    instr_type_out,
    output logic [1:0]           occupancy
);

    // Packed payload layout: {rs1, rs2, rd, instr, type}
    localparam int PAY_W = 2*XLEN + REG_IDX_W + INSTR_W + TYPE_W;

    // Bubble pattern: all fields zero except the instruction word
    localparam logic [PAY_W-1:0] NOP_PAYLOAD =
        {{(2*XLEN + REG_IDX_W){1'b0}}, NOP_INSTR, {TYPE_W{1'b0}}};

    // Occupancy state doubles as the occupancy output encoding
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } occ_state_e;

    // Source selection for the main register
    typedef enum logic [1:0] {
        MAIN_HOLD = 2'd0,
        MAIN_IN   = 2'd1,
        MAIN_SKID = 2'd2,
        MAIN_NOP  = 2'd3
    } main_sel_e;

    // Source selection for the skid register
    typedef enum logic [1:0] {
        SKID_HOLD = 2'd0,
        SKID_IN   = 2'd1,
        SKID_NOP  = 2'd2
    } skid_sel_e;

    occ_state_e       state_r;
    occ_state_e       state_next_s;
    main_sel_e        main_sel_s;
    skid_sel_e        skid_sel_s;
    logic             in_ready_s;
    logic             accept_s;
    logic             fire_s;
    logic             out_valid_r;
    logic [PAY_W-1:0] in_payload_s;
    logic [PAY_W-1:0] main_r;
    logic [PAY_W-1:0] skid_r;

    assign in_payload_s = {rs1_val, rs2_val, rd_idx, instr, instr_type};

    // Ready depends only on registered occupancy and flush, never on out_ready
    assign in_ready_s = (state_r != ST_TWO) & ~flush;
    assign accept_s   = in_valid & in_ready_s;
    assign fire_s     = out_valid_r & out_ready;

    // Occupancy state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_EMPTY;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state and payload steering; flush overrides every other transition
    always_comb begin
        state_next_s = state_r;
        main_sel_s   = MAIN_HOLD;
        skid_sel_s   = SKID_HOLD;
        if (flush) begin
            state_next_s = ST_EMPTY;
            main_sel_s   = MAIN_NOP;
            skid_sel_s   = SKID_NOP;
        end else begin
            case (state_r)
                ST_EMPTY: begin
                    if (accept_s) begin
                        state_next_s = ST_ONE;
                        main_sel_s   = MAIN_IN;
                    end else begin
                        state_next_s = ST_EMPTY;
                    end
                end
                ST_ONE: begin
                    if (accept_s && fire_s) begin
                        state_next_s = ST_ONE;
                        main_sel_s   = MAIN_IN;
                    end else if (fire_s) begin
                        state_next_s = ST_EMPTY;
                    end else if (accept_s) begin
                        state_next_s = ST_TWO;
                        skid_sel_s   = SKID_IN;
                    end else begin
                        state_next_s = ST_ONE;
                    end
                end
                ST_TWO: begin
                    if (fire_s) begin
                        state_next_s = ST_ONE;
                        main_sel_s   = MAIN_SKID;
                    end else begin
                        state_next_s = ST_TWO;
                    end
                end
                default: begin
                    // Unreachable encoding: recover to a clean empty stage
                    state_next_s = ST_EMPTY;
                    main_sel_s   = MAIN_NOP;
                    skid_sel_s   = SKID_NOP;
                end
            endcase
        end
    end

    // Registered valid, tracking whether the next state holds any beat
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_r <= 1'b0;
        end else begin
            out_valid_r <= (state_next_s != ST_EMPTY);
        end
    end

    // Main payload register, the beat currently presented to EX
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_r <= NOP_PAYLOAD;
        end else begin
            case (main_sel_s)
                MAIN_HOLD: main_r <= main_r;
                MAIN_IN:   main_r <= in_payload_s;
                MAIN_SKID: main_r <= skid_r;
                MAIN_NOP:  main_r <= NOP_PAYLOAD;
                default:   main_r <= NOP_PAYLOAD;
            endcase
        end
    end

    // Skid payload register, the second beat waiting behind main
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            skid_r <= NOP_PAYLOAD;
        end else begin
            case (skid_sel_s)
                SKID_HOLD: skid_r <= skid_r;
                SKID_IN:   skid_r <= in_payload_s;
                SKID_NOP:  skid_r <= NOP_PAYLOAD;
                default:   skid_r <= NOP_PAYLOAD;
            endcase
        end
    end

    assign in_ready  = in_ready_s;
    assign out_valid = out_valid_r;
    assign occupancy = state_r;
    assign {rs1_val_out, rs2_val_out, rd_idx_out, instr_out, instr_type_out} = main_r;

endmodule
